branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Tracks branches that the fetch stage predicts, in program order, and checks each one
//  against its actual outcome at the EX stage.
//  Produces the registered update (valid/pc/taken) that trains the 2-bit BHT predictor.
//  On a mispredict it flushes the pipeline and redirects the PC.
//  Sits between IF (producer of predictions) and EX (producer of outcomes).
// PARAMETERS
//  DEPTH    4    in-flight branch queue entries (power of two, >=2)
//  PC_W     8    PC width; matches BHT index width
//  CNT_W    16   statistics counter width
// PORTS
//  clk             in   1      clock, rising edge
//  reset           in   1      asynchronous, active-low reset
//  pred_valid      in   1      IF pushes a predicted branch this cycle
//  pred_pc         in   PC_W   PC of predicted branch
//  pred_taken      in   1      predicted direction from BHT
//  pred_target     in   PC_W   predicted target (ignored when pred_taken=0)
//  pred_ready      out  1      queue can accept a push (= !full)
//  resolve_valid   in   1      EX resolves oldest in-flight branch this cycle
//  resolve_taken   in   1      actual direction
//  resolve_target  in   PC_W   actual target
//  upd_valid       out  1      BHT update strobe (drives predictor 'branch')
//  upd_pc          out  PC_W   BHT index to update
//  upd_taken       out  1      actual outcome to train with
//  flush           out  1      one-cycle pipeline flush on mispredict
//  redirect_pc     out  PC_W   correct next PC, valid when flush=1
//  occupancy       out  log2(DEPTH)+1  entries currently in queue
//  branch_count    out  CNT_W  resolved branches, saturating
//  mispred_count   out  CNT_W  mispredicted branches, saturating
//  proto_err       out  1      sticky: resolve_valid seen while queue empty
// BEHAVIOUR
//  - Reset (async, reset=0): queue empty, all outputs 0, pred_ready=1, counters 0, proto_err=0.
//  - Queue: circular FIFO of {pc,taken,target}; rd/wr pointers wrap modulo DEPTH.
//  - Push: pred_valid & pred_ready. With pred_ready=0 the push is dropped; IF must hold.
//  - Resolve: resolve_valid & !empty pops the head entry H.
//  - Mispredict: H.taken!=resolve_taken, or (resolve_taken & H.target!=resolve_target).
//  - Latency: upd_*, flush, redirect_pc are registered; asserted exactly 1 cycle after resolve.
//    They deassert the next cycle unless another resolve occurs.
//  - upd_valid=1, upd_pc=H.pc, upd_taken=resolve_taken for every valid resolve.
//  - On mispredict: flush=1; redirect_pc = resolve_taken ? resolve_target : H.pc+1 (wraps mod 2^PC_W).
//  - On mispredict the whole queue is cleared at the resolving edge (younger entries are
//    wrong-path). A push in the same cycle is discarded.
//  - Simultaneous push+pop without mispredict: both occur; occupancy unchanged.
//  - Full + resolve in the same cycle: pred_ready stays 0 (no bypass); push is accepted next cycle.
//  - resolve_valid while empty: no pop, no upd_valid, proto_err set until reset.
//  - Counters: branch_count +1 per valid resolve; mispred_count +1 per mispredict.
//    Both saturate at 2^CNT_W-1.
//  - Reset mid-operation: asynchronous clear to the reset state above. An in-flight flush/upd is dropped.
// TESTING
//  1 Reset: hold reset=0 -> pred_ready=1, occupancy=0, flush=0, upd_valid=0, counters=0.
//  2 Correct predict: push pc=0x10 taken tgt=0x40; resolve taken tgt=0x40.
//    -> next cycle upd_valid=1, upd_pc=0x10, upd_taken=1, flush=0.
//  3 Direction mispredict: push pc=0xFF not-taken, push pc=0x20; resolve not... resolve taken tgt=0x08.
//    -> flush=1, redirect_pc=0x08, occupancy=0, mispred_count=1.
//  4 Fall-through wrap: push pc=0xFF taken tgt=0x30; resolve not-taken.
//    -> flush=1, redirect_pc=0x00, upd_taken=0.
//  5 Full: 4 pushes -> pred_ready=0, 5th push dropped; resolve+push same cycle
//    -> occupancy=3, then push accepted next cycle -> 4.
//  6 Empty resolve: resolve_valid with occupancy=0 -> proto_err=1, upd_valid=0, branch_count unchanged.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - in-order branch queue checking IF predictions against EX outcomes
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pred_valid,
    input  logic [PC_W-1:0]            pred_pc,
    input  logic                       pred_taken,
    input  logic [PC_W-1:0]            pred_target,
    output logic                       pred_ready,
    input  logic                       resolve_valid,
    input  logic                       resolve_taken,
    input  logic [PC_W-1:0]            resolve_target,
    output logic                       upd_valid,
    output logic [PC_W-1:0]            upd_pc,
    output logic                       upd_taken,
    output logic                       flush,
    output logic [PC_W-1:0]            redirect_pc,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [CNT_W-1:0]           branch_count,
    output logic [CNT_W-1:0]           mispred_count,
    output logic                       proto_err
);
    localparam int AW = $clog2(DEPTH);

    logic [PC_W-1:0] mem_pc     [DEPTH];
    logic            mem_taken  [DEPTH];
    logic [PC_W-1:0] mem_target [DEPTH];

    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [AW:0]     count;

    logic            empty, full;
    logic            do_pop, do_push, mispred;
    logic [PC_W-1:0] h_pc, h_target;
    logic            h_taken;

    assign empty      = (count == '0);
    assign full       = (count == (AW+1)'(DEPTH));
    assign pred_ready = !full;
    assign occupancy  = count;

    assign h_pc     = mem_pc[rd_ptr];
    assign h_taken  = mem_taken[rd_ptr];
    assign h_target = mem_target[rd_ptr];

    assign do_pop  = resolve_valid && !empty;
    assign mispred = do_pop && ((h_taken != resolve_taken) ||
                                (resolve_taken && (h_target != resolve_target)));
    // Anything pushed alongside a mispredict is wrong-path and is discarded.
    assign do_push = pred_valid && pred_ready && !mispred;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_pc[wr_ptr]     <= pred_pc;
            mem_taken[wr_ptr]  <= pred_taken;
            mem_target[wr_ptr] <= pred_target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            upd_valid     <= 1'b0;
            upd_pc        <= '0;
            upd_taken     <= 1'b0;
            flush         <= 1'b0;
            redirect_pc   <= '0;
            branch_count  <= '0;
            mispred_count <= '0;
            proto_err     <= 1'b0;
        end else begin
            upd_valid <= do_pop;
            flush     <= mispred;
            if (do_pop) begin
                upd_pc      <= h_pc;
                upd_taken   <= resolve_taken;
                redirect_pc <= resolve_taken ? resolve_target : h_pc + PC_W'(1);
                if (branch_count != '1)
                    branch_count <= branch_count + CNT_W'(1);
            end
            if (mispred && (mispred_count != '1))
                mispred_count <= mispred_count + CNT_W'(1);
            if (resolve_valid && empty)
                proto_err <= 1'b1;

            if (mispred) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)
                    rd_ptr <= rd_ptr + AW'(1);
                case ({do_push, do_pop})
                    2'b10:   count <= count + (AW+1)'(1);
                    2'b01:   count <= count - (AW+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;
    logic        clk;
    logic        reset;
    logic        pred_valid;
    logic [7:0]  pred_pc;
    logic        pred_taken;
    logic [7:0]  pred_target;
    logic        pred_ready;
    logic        resolve_valid;
    logic        resolve_taken;
    logic [7:0]  resolve_target;
    logic        upd_valid;
    logic [7:0]  upd_pc;
    logic        upd_taken;
    logic        flush;
    logic [7:0]  redirect_pc;
    logic [2:0]  occupancy;
    logic [15:0] branch_count;
    logic [15:0] mispred_count;
    logic        proto_err;

    int checks;
    int failures;

    branch_resolve_unit dut (
        .clk(clk), .reset(reset),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .pred_ready(pred_ready),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .flush(flush), .redirect_pc(redirect_pc), .occupancy(occupancy),
        .branch_count(branch_count), .mispred_count(mispred_count),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] pc, input logic tk, input logic [7:0] tgt);
        pred_valid  = 1'b1;
        pred_pc     = pc;
        pred_taken  = tk;
        pred_target = tgt;
    endtask

    task automatic resolve(input logic tk, input logic [7:0] tgt);
        resolve_valid  = 1'b1;
        resolve_taken  = tk;
        resolve_target = tgt;
    endtask

    task automatic idle();
        pred_valid    = 1'b0;
        resolve_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0; pred_target = '0;
        resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_target = '0;
        tick(); tick();

        // Reset state
        chk("rst_ready", pred_ready, 1);
        chk("rst_occ", occupancy, 0);
        chk("rst_flush", flush, 0);
        chk("rst_upd", upd_valid, 0);
        chk("rst_bcnt", branch_count, 0);
        chk("rst_mcnt", mispred_count, 0);
        chk("rst_perr", proto_err, 0);
        reset = 1'b1;
        tick();

        // Correct prediction
        push(8'h10, 1'b1, 8'h40); tick();
        chk("ok_occ1", occupancy, 1);
        idle(); resolve(1'b1, 8'h40); tick();
        chk("ok_upd", upd_valid, 1);
        chk("ok_pc", upd_pc, 8'h10);
        chk("ok_tk", upd_taken, 1);
        chk("ok_flush", flush, 0);
        chk("ok_occ0", occupancy, 0);
        chk("ok_bcnt", branch_count, 1);
        idle(); tick();
        chk("ok_upd_drop", upd_valid, 0);

        // Direction mispredict clears younger entry
        push(8'hFF, 1'b0, 8'h00); tick();
        push(8'h20, 1'b1, 8'h50); tick();
        chk("dir_occ2", occupancy, 2);
        idle(); resolve(1'b1, 8'h08); tick();
        chk("dir_flush", flush, 1);
        chk("dir_redir", redirect_pc, 8'h08);
        chk("dir_occ0", occupancy, 0);
        chk("dir_mcnt", mispred_count, 1);
        chk("dir_pc", upd_pc, 8'hFF);
        chk("dir_bcnt", branch_count, 2);
        idle(); tick();
        chk("dir_flush_drop", flush, 0);

        // Fall-through wraps to 0
        push(8'hFF, 1'b1, 8'h30); tick();
        idle(); resolve(1'b0, 8'h77); tick();
        chk("wrap_flush", flush, 1);
        chk("wrap_redir", redirect_pc, 8'h00);
        chk("wrap_tk", upd_taken, 0);
        chk("wrap_mcnt", mispred_count, 2);
        idle(); tick();

        // Fill queue
        for (int i = 1; i <= 4; i++) begin
            push(8'(i), 1'b1, 8'(i + 16)); tick();
        end
        chk("full_occ", occupancy, 4);
        chk("full_ready", pred_ready, 0);
        push(8'h05, 1'b1, 8'h15); tick();
        chk("full_drop", occupancy, 4);
        resolve(1'b1, 8'h11); tick();
        chk("full_rs_occ", occupancy, 3);
        chk("full_rs_pc", upd_pc, 8'h01);
        chk("full_rs_flush", flush, 0);
        chk("full_rs_ready", pred_ready, 1);
        idle(); push(8'h05, 1'b1, 8'h15); tick();
        chk("full_push_next", occupancy, 4);
        chk("full_bcnt", branch_count, 4);

        // Pop-only, then simultaneous push+pop
        idle(); resolve(1'b1, 8'h12); tick();
        chk("pp_occ3", occupancy, 3);
        chk("pp_pc2", upd_pc, 8'h02);
        push(8'h06, 1'b1, 8'h16); resolve(1'b1, 8'h13); tick();
        chk("pp_occ_same", occupancy, 3);
        chk("pp_pc3", upd_pc, 8'h03);
        chk("pp_flush", flush, 0);

        // Target mispredict with concurrent push discarded
        push(8'h07, 1'b1, 8'h17); resolve(1'b1, 8'h99); tick();
        chk("tgt_flush", flush, 1);
        chk("tgt_redir", redirect_pc, 8'h99);
        chk("tgt_pc4", upd_pc, 8'h04);
        chk("tgt_occ0", occupancy, 0);
        chk("tgt_mcnt", mispred_count, 3);
        chk("tgt_bcnt", branch_count, 7);
        idle(); tick();
        chk("tgt_occ_after", occupancy, 0);

        // Resolve on empty queue
        resolve(1'b1, 8'h00); tick();
        chk("emp_perr", proto_err, 1);
        chk("emp_upd", upd_valid, 0);
        chk("emp_bcnt", branch_count, 7);
        idle(); tick();
        chk("emp_perr_sticky", proto_err, 1);

        // Async reset mid-operation drops the pending update
        push(8'h33, 1'b0, 8'h00); tick();
        idle(); resolve(1'b1, 8'h44); tick();
        chk("mid_flush_pre", flush, 1);
        idle();
        #2 reset = 1'b0;
        #1;
        chk("mid_upd", upd_valid, 0);
        chk("mid_flush", flush, 0);
        chk("mid_perr", proto_err, 0);
        chk("mid_bcnt", branch_count, 0);
        chk("mid_occ", occupancy, 0);
        tick();
        reset = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
